// File: rtl/mem_access_stage.sv
// MEM pipeline stage: wait-stated, word-addressed data RAM behind an IDLE/BUSY/DONE FSM.
// Optional address fault detection is enabled by defining MEM_RANGE_CHECK_EN.
module mem_access_stage #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 6,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        dst,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] val_rm,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              wb_en,
   output logic [3:0]        dst_out,
   output logic [DATA_W-1:0] alu_res_out,
   output logic              mem_read_out,
   output logic              wb_en_out,
   output logic [DATA_W-1:0] mem_out,
   output logic              freeze,
   output logic              mem_err
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic [DATA_W-1:0] r_ram [DEPTH];
   logic [DATA_W-1:0] r_mem_out;
   logic              r_mem_err;

   logic              w_req;
   logic              w_access;
   logic              w_fault;
   logic              w_ram_we;
   logic              w_load;
   logic [ADDR_W-1:0] w_idx;

   assign w_req = mem_read | mem_write;
   assign w_idx = ADDR_W'((alu_res - DATA_W'(BASE_ADDR)) >> 2);

`ifdef MEM_RANGE_CHECK_EN
   logic [DATA_W-1:0] w_word;

   // Full (untruncated) word index, so out-of-range addresses are caught before wrapping.
   assign w_word  = (alu_res - DATA_W'(BASE_ADDR)) >> 2;
   assign w_fault = (alu_res < DATA_W'(BASE_ADDR))
                  | ((w_word >> ADDR_W) != '0)
                  | (alu_res[1:0] != 2'b00);
`else
   assign w_fault = 1'b0;
`endif

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_access    = 1'b0;
      freeze      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               freeze      = 1'b1;
               w_cnt_nxt   = 4'(WAIT_CYCLES);
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            freeze = 1'b1;
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_access    = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            // Inputs still belong to the finished instruction, so no request is taken here.
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // A reset landing on the access edge must not let the write through.
   assign w_ram_we = rst & w_access & mem_write & ~w_fault;
   assign w_load   = w_access & mem_read & ~mem_write;

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_mem_out <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_mem_err <= w_access & w_fault;
         if (w_load) begin
            r_mem_out <= w_fault ? '0 : r_ram[w_idx];
         end
      end
   end

   // NOTE: the RAM array has no reset so it maps onto a synchronous-write memory macro.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         r_ram[w_idx] <= val_rm;
      end
   end

   assign dst_out      = dst;
   assign alu_res_out  = alu_res;
   assign mem_read_out = mem_read;
   assign wb_en_out    = wb_en;
   assign mem_out      = r_mem_out;
   assign mem_err      = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized accesses
// against an array-based memory model. Honours MEM_RANGE_CHECK_EN when defined.
module tb_mem_access_stage;

   localparam int          DATA_W = 32;
   localparam int          ADDR_W = 6;
   localparam int          DEPTH  = 64;
   localparam int          WAITS  = 2;
   localparam logic [31:0] BASE   = 32'd1024;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        dst;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] val_rm;
   logic              mem_read;
   logic              mem_write;
   logic              wb_en;
   logic [3:0]        dst_out;
   logic [DATA_W-1:0] alu_res_out;
   logic              mem_read_out;
   logic              wb_en_out;
   logic [DATA_W-1:0] mem_out;
   logic              freeze;
   logic              mem_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mdl [DEPTH];
   logic [31:0] m_out;

   mem_access_stage #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .BASE_ADDR  (1024),
      .WAIT_CYCLES(WAITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dst         (dst),
      .alu_res     (alu_res),
      .val_rm      (val_rm),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .wb_en       (wb_en),
      .dst_out     (dst_out),
      .alu_res_out (alu_res_out),
      .mem_read_out(mem_read_out),
      .wb_en_out   (wb_en_out),
      .mem_out     (mem_out),
      .freeze      (freeze),
      .mem_err     (mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int unsigned m_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off / 4) % DEPTH);
   endfunction

   function automatic bit m_fault(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
      logic [31:0] off;
      off = a - BASE;
      return (a < BASE) || ((off / 4) >= DEPTH) || ((a % 4) != 0);
`else
      return (a != a);
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // One memory access: drive, count frozen cycles, compare the DONE cycle with the model.
   task automatic test_access_txn(input string name, input logic [31:0] addr,
                                  input logic [31:0] data, input bit rd, input bit wr,
                                  input bit in_done, input bit stay);
      int          cycles;
      bit          flt;
      int unsigned ix;
      alu_res   = addr;
      val_rm    = data;
      mem_read  = rd;
      mem_write = wr;
      dst       = 4'($urandom);
      wb_en     = 1'($urandom);
      #1;
      if (in_done) begin
         n_tests++;
         if (freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_freeze: got %b want 0", name, freeze);
         end
         tick();
      end
      cycles = 0;
      while (freeze === 1'b1 && cycles < 40) begin
         tick();
         cycles++;
      end
      flt = m_fault(addr);
      ix  = m_idx(addr);
      if (wr) begin
         if (!flt) mdl[ix] = data;
      end else if (rd) begin
         m_out = flt ? 32'h0 : mdl[ix];
      end
      n_tests++;
      if (cycles != WAITS + 2) begin
         n_fail++;
         $display("FAIL %s freeze_len: got %0d want %0d", name, cycles, WAITS + 2);
      end
      n_tests++;
      if (mem_out !== m_out) begin
         n_fail++;
         $display("FAIL %s mem_out: got %h want %h", name, mem_out, m_out);
      end
      n_tests++;
      if (mem_err !== flt) begin
         n_fail++;
         $display("FAIL %s mem_err: got %b want %b", name, mem_err, flt);
      end
      n_tests++;
      if (dst_out !== dst || alu_res_out !== alu_res || mem_read_out !== mem_read ||
          wb_en_out !== wb_en) begin
         n_fail++;
         $display("FAIL %s passthru: got %h/%h/%b/%b want %h/%h/%b/%b", name, dst_out,
                  alu_res_out, mem_read_out, wb_en_out, dst, alu_res, mem_read, wb_en);
      end
      if (!stay) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         tick();
         n_tests++;
         if (freeze !== 1'b0 || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: got freeze=%b err=%b want 0/0", name, freeze, mem_err);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      dst = 4'h0; alu_res = '0; val_rm = '0; wb_en = 1'b0;
      repeat (3) tick();
      m_out = 32'h0;
      n_tests++;
      if (freeze !== 1'b0 || mem_out !== 32'h0 || mem_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got freeze=%b out=%h err=%b want 0/0/0", freeze, mem_out, mem_err);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_passthrough;
      dst = 4'h3; wb_en = 1'b1; alu_res = $urandom; mem_read = 1'b0; mem_write = 1'b0;
      #1;
      n_tests++;
      if (dst_out !== 4'h3 || wb_en_out !== 1'b1 || alu_res_out !== alu_res || freeze !== 1'b0) begin
         n_fail++;
         $display("FAIL passthru_nomem: got dst=%h wb=%b alu=%h frz=%b want 3/1/%h/0",
                  dst_out, wb_en_out, alu_res_out, freeze, alu_res);
      end
      tick();
      n_tests++;
      if (freeze !== 1'b0) begin
         n_fail++;
         $display("FAIL nomem_freeze: got %b want 0", freeze);
      end
   endtask

   task automatic test_write_read;
      test_access_txn("wr1024", 32'd1024, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
      test_access_txn("rd1024", 32'd1024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_abort;
      test_access_txn("wr1028", 32'd1028, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      alu_res = 32'd1028; val_rm = 32'h5; mem_read = 1'b0; mem_write = 1'b1;
      tick();
      tick();
      rst = 1'b0; mem_write = 1'b0;
      tick();
      m_out = 32'h0;
      n_tests++;
      if (freeze !== 1'b0 || mem_out !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_reset: got freeze=%b out=%h want 0/0", freeze, mem_out);
      end
      rst = 1'b1;
      tick();
      test_access_txn("rd1028_after_abort", 32'd1028, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_rd_wr_both;
      test_access_txn("both1032", 32'd1032, 32'h7, 1'b1, 1'b1, 1'b0, 1'b0);
      test_access_txn("rd1032", 32'd1032, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

`ifdef MEM_RANGE_CHECK_EN
   task automatic test_range;
      test_access_txn("wr1000_fault", 32'd1000, 32'h9, 1'b0, 1'b1, 1'b0, 1'b0);
      test_access_txn("rd1026_fault", 32'd1026, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      test_access_txn("rd1024_ok", 32'd1024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask
`else
   task automatic test_wrap;
      test_access_txn("wr1280_wrap", 32'd1280, 32'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
      test_access_txn("rd1024_wrap", 32'd1024, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask
`endif

   // Second request presented in DONE: one unfrozen cycle, then a full access (spacing W+3).
   task automatic test_back_to_back;
      test_access_txn("b2b_wr", 32'd1036, $urandom, 1'b0, 1'b1, 1'b0, 1'b1);
      test_access_txn("b2b_rd", 32'd1036, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      test_access_txn("b2b_rd2", 32'd1024, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random;
      logic [31:0] a;
      int          kind;
      for (int i = 0; i < DEPTH; i++) begin
         test_access_txn("preload", BASE + 32'(4 * i), $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int i = 0; i < 60; i++) begin
         a    = BASE - 32'd8 + 32'($urandom_range(0, 4 * DEPTH + 24));
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            dst = 4'($urandom); wb_en = 1'($urandom); alu_res = a;
            mem_read = 1'b0; mem_write = 1'b0;
            #1;
            n_tests++;
            if (freeze !== 1'b0 || dst_out !== dst || alu_res_out !== a) begin
               n_fail++;
               $display("FAIL rand_nomem: got frz=%b dst=%h alu=%h want 0/%h/%h",
                        freeze, dst_out, alu_res_out, dst, a);
            end
            tick();
         end else begin
            test_access_txn("rand", a, $urandom, kind != 2, kind != 1, 1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_write_read();
      test_reset_abort();
      test_rd_wr_both();
`ifdef MEM_RANGE_CHECK_EN
      test_range();
`else
      test_wrap();
`endif
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage that sits between the EXE/MEM and MEM/WB pipeline registers. It replaces the zero-latency data-memory access with a wait-stated, word-addressed data RAM driven by a small state machine. While an access is in flight it raises `freeze` so the upstream pipeline holds. Writeback control signals pass straight through to MEM/WB.

## Interface
Parameters:
- `DATA_W`, 32: data and address width.
- `ADDR_W`, 6: word-index width; RAM depth is 2^ADDR_W words.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_CYCLES`, 2: extra wait states per access, 0..15.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `dst`, in, 4: destination register.
- `alu_res`, in, DATA_W: byte address or ALU result.
- `val_rm`, in, DATA_W: store data.
- `mem_read`, in, 1: load request.
- `mem_write`, in, 1: store request.
- `wb_en`, in, 1: writeback enable.
- `dst_out`, out, 4: pass-through of `dst`.
- `alu_res_out`, out, DATA_W: pass-through of `alu_res`.
- `mem_read_out`, out, 1: pass-through of `mem_read`.
- `wb_en_out`, out, 1: pass-through of `wb_en`.
- `mem_out`, out, DATA_W: registered load data.
- `freeze`, out, 1: stall request to hazard/pipeline-register logic.
- `mem_err`, out, 1: access fault flag, valid in DONE.

## Operation
- Word index is ((alu_res − BASE_ADDR) >> 2), truncated to ADDR_W bits.
- Request is `mem_read | mem_write`. If both are high, the access is a write and `mem_out` is unchanged.
- FSM states are IDLE, BUSY and DONE, with a 4-bit wait counter `cnt`.
  - IDLE: on a request, load `cnt`=WAIT_CYCLES and go to BUSY. Otherwise stay in IDLE.
  - BUSY: if `cnt`≠0, decrement it. If `cnt`=0, perform the access on this edge and go to DONE:
    - write: RAM[idx] ← val_rm.
    - read: mem_out ← RAM[idx].
  - DONE: go to IDLE unconditionally. No request is sampled in DONE, because the inputs still belong to the completed instruction.
- `freeze` = (state==IDLE & request) | (state==BUSY). It is combinational and is 0 in DONE.
- The upstream pipeline holds the inputs stable while `freeze`=1. The inputs are not registered in this block.
- The pass-through outputs are purely combinational.
- `mem_out` holds its value until the next completed read.
- RAM contents are not reset and are inferred as synchronous-write RAM. The bench preloads by writes.

## Timing
- Reset (rst=0 at an edge): state=IDLE, cnt=0, mem_out=0, mem_err=0, freeze=0 once no request is pending.
- Reset during BUSY aborts the access:
  - a write not yet at its access edge is not performed;
  - mem_out keeps its reset value 0.
- Access latency: the request is seen in IDLE at cycle 0, the access happens at the end of cycle WAIT_CYCLES+1, and DONE is cycle WAIT_CYCLES+2.
- `freeze` is high for exactly WAIT_CYCLES+2 cycles per access. Load data is valid on `mem_out` in the DONE cycle, when MEM/WB captures it.
- Back-to-back accesses: DONE→IDLE adds one non-frozen cycle between accesses. The minimum spacing is WAIT_CYCLES+3 cycles.
- Non-memory instruction: freeze=0 and the block is transparent with zero latency.

## Configuration
- Macro: `MEM_RANGE_CHECK_EN`.
- Defined: a fault is any of the following:
  - alu_res < BASE_ADDR;
  - untruncated word index ≥ 2^ADDR_W;
  - alu_res[1:0] ≠ 0.
- Faulting accesses still run the full FSM and freeze timing. The write is suppressed and a read loads `mem_out`=0. `mem_err`=1 in DONE only, cleared in IDLE.
- Undefined: `mem_err` is tied to 0, alu_res[1:0] are ignored, and the index wraps modulo 2^ADDR_W.

## Test plan
- Reset with no request: freeze=0, mem_out=0. Then mem_read=0, mem_write=0, dst=4'h3, wb_en=1 → dst_out=4'h3 and wb_en_out=1 in the same cycle, freeze stays 0.
- Write 1024←32'hDEADBEEF, then read 1024 (WAIT_CYCLES=2): freeze is high for 4 cycles per access; in the read's DONE, mem_out=32'hDEADBEEF and freeze=0.
- Write 1028←32'h11, then write 1028←32'h5 with rst=0 pulsed during its BUSY, then read 1028 → mem_out=32'h11, and the FSM restarts from IDLE after reset.
- mem_read=mem_write=1 at 1032 with val_rm=32'h7 (mem_out previously 32'h11) → mem_out stays 32'h11; a later read of 1032 returns 32'h7.
- `MEM_RANGE_CHECK_EN` defined:
  - write 1000←32'h9 → mem_err=1 in DONE, no RAM change;
  - read 1026 → mem_err=1, mem_out=0;
  - read 1024 → mem_err=0.
- `MEM_RANGE_CHECK_EN` undefined, ADDR_W=6: write 1280←32'hA5 (index 64 wraps to 0), then read 1024 → mem_out=32'hA5, mem_err=0.
